// File: rtl/qspi_mem_controller.sv
// qspi_mem_controller
// Bridges a word-read / double-word-write request port onto an external
// quad-SPI SRAM/PSRAM that is already in QPI mode. Command, address and data
// phases all move one nibble per ram_clk, and ram_clk runs at clk/2.
//
// Ports
//   clk         system clock, all state changes on the rising edge
//   rst_n       asynchronous active-low reset
//   mem_addr    32-bit-word address (device byte address = {2'b00, mem_addr, 2'b00})
//   mem_read    level request: read one 32-bit word
//   mem_write   level request: write 64 bits (words mem_addr and mem_addr+1)
//   mem_ready   one-clk completion pulse
//   mem_rddata  read data, updated with mem_ready on reads and held otherwise
//   mem_wrdata  write data, captured when a write starts
//   ram_clk     QSPI clock, idles low
//   ram_cs_n    QSPI chip select, active low
//   ram_io      QSPI data, driven in command/address/write phases, Hi-Z otherwise
module qspi_mem_controller #(
  parameter int unsigned DUMMY_CYCLES = 5,
  parameter logic [7:0]  CMD_READ     = 8'h0B,
  parameter logic [7:0]  CMD_WRITE    = 8'h38
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [19:0] mem_addr,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic        mem_ready,
  output logic [31:0] mem_rddata,
  input  logic [63:0] mem_wrdata,
  output logic        ram_clk,
  output logic        ram_cs_n,
  inout  wire  [3:0]  ram_io
);

  // STOP is the final low half-period that closes the last data nibble
  // before chip select is released in DONE.
  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    RDATA,
    WDATA,
    STOP,
    DONE
  } state_e;

  // DUMMY_CYCLES is expected to stay below 32 so the nibble counter can hold it.
  localparam logic [4:0] DUMMY_LAST = 5'(DUMMY_CYCLES - 1);

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic        rd_q;
  logic [91:0] sh_q;
  logic [3:0]  io_out_q;
  logic        io_oe_q;
  logic        ram_clk_q;
  logic        cs_n_q;
  logic        ready_q;
  logic [31:0] rddata_q;
  logic [31:0] rdsh_q;

  // The transaction is one long nibble stream: opcode, 24-bit address, then
  // write data. The first nibble goes straight to the pins at start and the
  // rest waits in sh_q, leaving MSB-first on every falling ram_clk.
  // Each nibble takes two clk: a low half where the pins change and a high
  // half where the device samples. On reads the nibble is captured at the
  // edge that raises ram_clk, because the device launched it on the
  // preceding fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rd_q      <= 1'b0;
      sh_q      <= '0;
      io_out_q  <= '0;
      io_oe_q   <= 1'b0;
      ram_clk_q <= 1'b0;
      cs_n_q    <= 1'b1;
      ready_q   <= 1'b0;
      rddata_q  <= '0;
      rdsh_q    <= '0;
    end else begin
      ready_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // Read wins over a simultaneous write.
          if (mem_read || mem_write) begin
            rd_q      <= mem_read;
            cs_n_q    <= 1'b0;
            ram_clk_q <= 1'b0;
            io_oe_q   <= 1'b1;
            cnt_q     <= '0;
            state_q   <= CMD;
            if (mem_read) begin
              io_out_q <= CMD_READ[7:4];
              sh_q     <= {CMD_READ[3:0], 2'b00, mem_addr, 2'b00, 64'h0};
            end else begin
              io_out_q <= CMD_WRITE[7:4];
              sh_q     <= {CMD_WRITE[3:0], 2'b00, mem_addr, 2'b00, mem_wrdata};
            end
          end
        end

        STOP: begin
          cs_n_q  <= 1'b1;
          ready_q <= 1'b1;
          if (rd_q) begin
            rddata_q <= rdsh_q;
          end
          state_q <= DONE;
        end

        DONE: begin
          state_q <= IDLE;
        end

        default: begin
          if (!ram_clk_q) begin
            ram_clk_q <= 1'b1;
            if (state_q == RDATA) begin
              rdsh_q <= {rdsh_q[27:0], ram_io};
            end
          end else begin
            // Shifting while the bus is released is harmless because io_oe_q is low.
            ram_clk_q <= 1'b0;
            cnt_q     <= cnt_q + 5'd1;
            io_out_q  <= sh_q[91:88];
            sh_q      <= {sh_q[87:0], 4'h0};
            case (state_q)
              CMD: begin
                if (cnt_q == 5'd1) begin
                  cnt_q   <= '0;
                  state_q <= ADDR;
                end
              end
              ADDR: begin
                if (cnt_q == 5'd5) begin
                  cnt_q <= '0;
                  if (rd_q) begin
                    io_oe_q <= 1'b0;
                    state_q <= (DUMMY_CYCLES == 0) ? RDATA : DUMMY;
                  end else begin
                    state_q <= WDATA;
                  end
                end
              end
              DUMMY: begin
                if (cnt_q == DUMMY_LAST) begin
                  cnt_q   <= '0;
                  state_q <= RDATA;
                end
              end
              RDATA: begin
                if (cnt_q == 5'd7) begin
                  state_q <= STOP;
                end
              end
              WDATA: begin
                if (cnt_q == 5'd15) begin
                  io_oe_q <= 1'b0;
                  state_q <= STOP;
                end
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  assign ram_io     = io_oe_q ? io_out_q : 4'bzzzz;
  assign ram_clk    = ram_clk_q;
  assign ram_cs_n   = cs_n_q;
  assign mem_ready  = ready_q;
  assign mem_rddata = rddata_q;

endmodule

// File: tb/tb_qspi_mem_controller.sv
// tb_qspi_mem_controller
// Bench for qspi_mem_controller. A small QPI SRAM stub answers reads. A
// transaction-level timeline model predicts every pin and port on every clk.
// Directed cases pin the model with literal nibble streams and latencies.
module tb_qspi_mem_controller;

   localparam int D = 5;
   localparam logic [7:0] OP_RD = 8'h0B;
   localparam logic [7:0] OP_WR = 8'h38;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [19:0] mem_addr = '0;
   logic        mem_read = 1'b0;
   logic        mem_write = 1'b0;
   logic [63:0] mem_wrdata = '0;
   logic        mem_ready;
   logic [31:0] mem_rddata;
   logic        ram_clk;
   logic        ram_cs_n;
   wire  [3:0]  ram_io;

   int checks = 0;
   int errors = 0;

   pullup pu0 (ram_io[0]);
   pullup pu1 (ram_io[1]);
   pullup pu2 (ram_io[2]);
   pullup pu3 (ram_io[3]);

   qspi_mem_controller #(.DUMMY_CYCLES(D), .CMD_READ(OP_RD), .CMD_WRITE(OP_WR)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .mem_addr   (mem_addr),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .mem_ready  (mem_ready),
      .mem_rddata (mem_rddata),
      .mem_wrdata (mem_wrdata),
      .ram_clk    (ram_clk),
      .ram_cs_n   (ram_cs_n),
      .ram_io     (ram_io)
   );

   always #5 clk = ~clk;

   // The memory stub counts rising ram_clk edges within a select. It decodes
   // the opcode from the first two nibbles. For a fast read it launches
   // devWord MSB-first on the falls that precede rising edges 9+D .. 16+D.
   int          devRise = 0;
   logic [7:0]  devCmd = '0;
   logic [31:0] devWord = '0;
   logic [31:0] devWordNext = '0;
   logic        devOe = 1'b0;
   logic [3:0]  devNib = '0;

   assign ram_io = (devOe && !ram_cs_n) ? devNib : 4'bzzzz;

   always @(negedge ram_cs_n) begin
      devRise = 0;
      devCmd  = '0;
      devOe   = 1'b0;
      devWord = devWordNext;
   end

   always @(posedge ram_cs_n) devOe = 1'b0;

   always @(posedge ram_clk) begin
      if (!ram_cs_n) begin
         devRise = devRise + 1;
         if (devRise <= 2) devCmd = {devCmd[3:0], ram_io};
      end
   end

   always @(negedge ram_clk) begin
      if (!ram_cs_n && devCmd == OP_RD && devRise >= 8 + D && devRise < 16 + D) begin
         devOe  = 1'b1;
         devNib = devWord[31 - 4 * (devRise - (8 + D)) -: 4];
      end else begin
         devOe = 1'b0;
      end
   end

   // The reference model is a timeline. A transaction accepted at edge E0
   // spans L = 2*nibbles+1 clocks. Nibble n is presented in clocks 2n and
   // 2n+1, and ram_clk is high on the odd clock. One low clock follows the
   // last nibble. Clock L is the ready cycle and clock L+1 is idle. The next
   // request can be taken one edge later.
   logic        mActive = 1'b0;
   int          mI = 0;
   int          mL = 0;
   logic        mIsRead = 1'b0;
   logic [95:0] mNibs = '0;
   logic [31:0] mDevWord = '0;
   logic [31:0] mRdData = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mActive = 1'b0;
         mI      = 0;
         mRdData = '0;
      end else if (mActive) begin
         mI = mI + 1;
         if (mI == mL && mIsRead) mRdData = mDevWord;
         if (mI == mL + 1) mActive = 1'b0;
      end else if (mem_read || mem_write) begin
         mActive  = 1'b1;
         mI       = 0;
         mIsRead  = mem_read;
         mDevWord = devWordNext;
         if (mem_read) begin
            mL    = 2 * (16 + D) + 1;
            mNibs = {OP_RD, 2'b00, mem_addr, 2'b00, 64'h0};
         end else begin
            mL    = 2 * 24 + 1;
            mNibs = {OP_WR, 2'b00, mem_addr, 2'b00, mem_wrdata};
         end
      end
   end

   // Returns {check, nibble}. A released bus reads F through the pullups.
   function automatic logic [4:0] expIo();
      int n;
      if (!mActive || mI >= mL) return {1'b1, 4'hF};
      if (mI == mL - 1) return mIsRead ? {1'b1, 4'hF} : 5'h00;
      n = mI / 2;
      if (n < 8 || !mIsRead) return {1'b1, mNibs[95 - 4 * n -: 4]};
      if (n < 8 + D) return {1'b1, 4'hF};
      return {1'b1, mDevWord[31 - 4 * (n - 8 - D) -: 4]};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("[TB] FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Every falling clk edge compares all outputs against the timeline model.
   always @(negedge clk) begin
      logic [4:0] io;
      if ($time > 2) begin
         checkOutput("ram_cs_n", 32'(ram_cs_n), 32'(!(mActive && mI < mL)));
         checkOutput("ram_clk", 32'(ram_clk), 32'(mActive && mI < mL - 1 && (mI % 2 == 1)));
         checkOutput("mem_ready", 32'(mem_ready), 32'(mActive && mI == mL));
         checkOutput("mem_rddata", mem_rddata, mRdData);
         io = expIo();
         if (io[4]) checkOutput("ram_io", 32'(ram_io), 32'(io[3:0]));
      end
   end

   // Observation of the pins for the literal checks.
   int         cyc = 0;
   logic       capOn = 1'b0;
   logic [3:0] capQ[$];
   int         csFallCyc = 0;
   int         readyCyc = -1;
   int         lastLat = 0;
   int         lastGap = 0;
   int         readyCount = 0;
   logic       prevCs = 1'b1;

   always @(posedge clk) cyc = cyc + 1;

   always @(negedge clk) begin
      if (capOn && !ram_cs_n && ram_clk) capQ.push_back(ram_io);
      if (prevCs && !ram_cs_n) begin
         csFallCyc = cyc;
         if (readyCyc >= 0) lastGap = cyc - readyCyc;
      end
      if (mem_ready) begin
         lastLat    = cyc - csFallCyc;
         readyCyc   = cyc;
         readyCount = readyCount + 1;
      end
      prevCs = ram_cs_n;
   end

   task automatic applyStimulus(input logic rd, input logic wr, input logic [19:0] a, input logic [63:0] d);
      mem_read   = rd;
      mem_write  = wr;
      mem_addr   = a;
      mem_wrdata = d;
   endtask

   task automatic waitReady(input int maxCyc, input bit scramble);
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < maxCyc; k++) begin
         @(posedge clk);
         #2;
         if (mem_ready) begin
            ok = 1'b1;
            break;
         end
         if (scramble) begin
            mem_addr   = 20'($urandom);
            mem_wrdata = {$urandom, $urandom};
         end
      end
      if (!ok) begin
         checks = checks + 1;
         errors = errors + 1;
         $display("[TB] FAIL ready_timeout actual=none required=pulse within %0d clk", maxCyc);
      end
   endtask

   task automatic startCapture();
      capQ.delete();
      readyCount = 0;
      capOn = 1'b1;
   endtask

   initial begin
      logic [3:0]  rdHdr [8];
      logic [3:0]  wrNib [24];
      logic [31:0] w;

      rdHdr = '{4'h0, 4'hB, 4'h0, 4'h4, 4'h8, 4'hD, 4'h1, 4'h4};
      wrNib = '{4'h3, 4'h8, 4'h1, 4'h9, 4'hE, 4'h2, 4'h6, 4'h8,
                4'hA, 4'hD, 4'hD, 4'h7, 4'h0, 4'hA, 4'h5, 4'h7,
                4'hE, 4'hD, 4'hC, 4'h0, 4'hF, 4'hF, 4'hE, 4'hE};

      // Reset, then a long quiet stretch with no request.
      #1 rst_n = 1'b0;
      repeat (5) @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #2;
      checkOutput("idle_rddata", mem_rddata, 32'h0);
      checkOutput("idle_io", 32'(ram_io), 32'hF);

      // Directed read of word 0x12345, with the device returning 0..7.
      devWordNext = 32'h01234567;
      startCapture();
      applyStimulus(1'b1, 1'b0, 20'h12345, 64'h0);
      waitReady(200, 1'b0);
      applyStimulus(1'b0, 1'b0, 20'h0, 64'h0);
      repeat (4) @(posedge clk);
      #2 capOn = 1'b0;
      checkOutput("rd_nibble_count", 32'(capQ.size()), 32'd21);
      if (capQ.size() == 21) begin
         for (int k = 0; k < 8; k++) checkOutput("rd_hdr_nibble", 32'(capQ[k]), 32'(rdHdr[k]));
         for (int k = 0; k < 8; k++) checkOutput("rd_data_nibble", 32'(capQ[13 + k]), 32'(k));
      end
      checkOutput("rd_data", mem_rddata, 32'h01234567);
      checkOutput("rd_latency", 32'(lastLat), 32'd43);
      checkOutput("rd_ready_pulses", 32'(readyCount), 32'd1);

      // Directed write of two words at 0x6789A.
      startCapture();
      applyStimulus(1'b0, 1'b1, 20'h6789A, 64'hADD70A57EDC0FFEE);
      waitReady(200, 1'b0);
      applyStimulus(1'b0, 1'b0, 20'h0, 64'h0);
      repeat (4) @(posedge clk);
      #2 capOn = 1'b0;
      checkOutput("wr_nibble_count", 32'(capQ.size()), 32'd24);
      if (capQ.size() == 24) begin
         for (int k = 0; k < 24; k++) checkOutput("wr_nibble", 32'(capQ[k]), 32'(wrNib[k]));
      end
      checkOutput("wr_latency", 32'(lastLat), 32'd49);
      checkOutput("wr_ready_pulses", 32'(readyCount), 32'd1);
      checkOutput("wr_cs_high", 32'(ram_cs_n), 32'd1);
      checkOutput("wr_keeps_rddata", mem_rddata, 32'h01234567);

      // Read and write requested together: the read goes first.
      devWordNext = 32'hCAFE1234;
      startCapture();
      applyStimulus(1'b1, 1'b1, 20'h00010, 64'h1122334455667788);
      waitReady(200, 1'b0);
      mem_read = 1'b0;
      waitReady(200, 1'b0);
      applyStimulus(1'b0, 1'b0, 20'h0, 64'h0);
      repeat (4) @(posedge clk);
      #2 capOn = 1'b0;
      checkOutput("both_nibble_count", 32'(capQ.size()), 32'd45);
      if (capQ.size() == 45) begin
         checkOutput("both_first_op_hi", 32'(capQ[0]), 32'h0);
         checkOutput("both_first_op_lo", 32'(capQ[1]), 32'hB);
         checkOutput("both_second_op_hi", 32'(capQ[21]), 32'h3);
         checkOutput("both_second_op_lo", 32'(capQ[22]), 32'h8);
      end
      checkOutput("both_rddata", mem_rddata, 32'hCAFE1234);
      checkOutput("both_ready_pulses", 32'(readyCount), 32'd2);

      // Read held across completion: back-to-back reads with a cs_n gap.
      devWordNext = 32'h0BADF00D;
      applyStimulus(1'b1, 1'b0, 20'hABCDE, 64'h0);
      waitReady(200, 1'b0);
      devWordNext = 32'h5EED5EED;
      waitReady(200, 1'b0);
      applyStimulus(1'b0, 1'b0, 20'h0, 64'h0);
      checkOutput("held_cs_gap_ok", 32'(lastGap >= 2), 32'd1);
      checkOutput("held_rddata", mem_rddata, 32'h5EED5EED);
      repeat (3) @(posedge clk);

      // Reset during the dummy phase of a read, then a clean read.
      devWordNext = 32'h87654321;
      readyCount = 0;
      applyStimulus(1'b1, 1'b0, 20'h00FFF, 64'h0);
      repeat (20) @(posedge clk);
      #2 rst_n = 1'b0;
      applyStimulus(1'b0, 1'b0, 20'h0, 64'h0);
      @(negedge clk);
      checkOutput("abort_cs", 32'(ram_cs_n), 32'd1);
      checkOutput("abort_io", 32'(ram_io), 32'hF);
      checkOutput("abort_no_ready", 32'(readyCount), 32'd0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      checkOutput("abort_rddata_cleared", mem_rddata, 32'h0);
      devWordNext = 32'h13579BDF;
      applyStimulus(1'b1, 1'b0, 20'h00FFF, 64'h0);
      waitReady(200, 1'b0);
      applyStimulus(1'b0, 1'b0, 20'h0, 64'h0);
      checkOutput("after_abort_rddata", mem_rddata, 32'h13579BDF);
      repeat (3) @(posedge clk);

      // Random traffic. Inputs are scrambled after start to show they are latched.
      for (int t = 0; t < 40; t++) begin
         w = $urandom;
         devWordNext = $urandom;
         applyStimulus(w[0], w[1] | ~w[0], 20'($urandom), {$urandom, $urandom});
         waitReady(200, 1'b1);
         applyStimulus(1'b0, 1'b0, 20'($urandom), {$urandom, $urandom});
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #2;
      end
      repeat (5) @(posedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog actual=running required=finished");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
